led_dimmer: RTL and testbench

LED_DIMMER -- requirements
Module: led_dimmer

---
 rtl/led_dimmer.sv | 112 +++++++++++
 tb/tb_led_dimmer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/led_dimmer.sv
// LED dimmer/blinker: gates an active-low LED pattern with an 8-bit PWM and an
// optional blink phase, configured through a small 4-register write bus.
module led_dimmer #(
    parameter int BLINK_W = 24
) (
    input  logic         CLK_I,
    input  logic         RST_I,
    input  logic         WE_I,
    input  logic [1:0]   ADR_I,
    input  logic [31:0]  DAT_I,
    output logic [31:0]  DAT_O,
    input  logic [15:0]  LED_IN,
    output logic [15:0]  LED_OUT
);

    localparam logic [1:0] ADR_CTRL   = 2'd0;
    localparam logic [1:0] ADR_DUTY   = 2'd1;
    localparam logic [1:0] ADR_HALF   = 2'd2;
    localparam logic [1:0] ADR_STATUS = 2'd3;

    logic [1:0]         ctrl_q, ctrl_d;
    logic [7:0]         duty_q, duty_d;
    logic [BLINK_W-1:0] half_q, half_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [15:0]        led_q, led_d;

    logic               wr_ctrl, wr_duty, wr_half;
    logic [BLINK_W-1:0] blink_term;
    logic               pwm_on, gate;
    logic               unused_dat;

    assign unused_dat = ^DAT_I;

    assign wr_ctrl = WE_I && (ADR_I == ADR_CTRL);
    assign wr_duty = WE_I && (ADR_I == ADR_DUTY);
    assign wr_half = WE_I && (ADR_I == ADR_HALF);

    // A half-period of 0 is treated as 1, i.e. terminal count at 0.
    assign blink_term = (half_q == '0) ? '0 : half_q - BLINK_W'(1);

    assign pwm_on = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
    assign gate   = ctrl_q[0] ? (pwm_on && phase_q) : 1'b1;
    assign led_d  = ~(~LED_IN & {16{gate}});

    always_comb begin
        ctrl_d      = ctrl_q;
        duty_d      = duty_q;
        half_d      = half_q;
        pwm_cnt_d   = pwm_cnt_q + 8'd1;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        // A BLINK_HALF write beats a simultaneous terminal count.
        if (!ctrl_q[1]) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (wr_half) begin
            blink_cnt_d = '0;
        end else if (blink_cnt_q == blink_term) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

        if (wr_ctrl) begin
            ctrl_d = DAT_I[1:0];
            if (!DAT_I[1]) begin
                phase_d     = 1'b1;
                blink_cnt_d = '0;
            end
        end
        if (wr_duty) duty_d = DAT_I[7:0];
        if (wr_half) half_d = DAT_I[BLINK_W-1:0];
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ctrl_q      <= '0;
            duty_q      <= 8'hFF;
            half_q      <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            led_q       <= 16'hFFFF;
        end else begin
            ctrl_q      <= ctrl_d;
            duty_q      <= duty_d;
            half_q      <= half_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

    assign LED_OUT = led_q;

    always_comb begin
        DAT_O = '0;
        case (ADR_I)
            ADR_CTRL:   DAT_O = {30'd0, ctrl_q};
            ADR_DUTY:   DAT_O = {24'd0, duty_q};
            ADR_HALF:   DAT_O = 32'(half_q);
            ADR_STATUS: DAT_O = {16'd0, pwm_cnt_q, 7'd0, phase_q};
            default:    DAT_O = '0;
        endcase
    end

endmodule

// File: tb/tb_led_dimmer.sv
// Randomized + directed bench for led_dimmer; expectations come from an
// integer-arithmetic reference model and are checked through a scoreboard queue.
module tb_led_dimmer;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        WE_I  = 1'b0;
    logic [1:0]  ADR_I = 2'd0;
    logic [31:0] DAT_I = '0;
    logic [31:0] DAT_O;
    logic [15:0] LED_IN = 16'h0000;
    logic [15:0] LED_OUT;

    led_dimmer #(.BLINK_W(24)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .WE_I(WE_I), .ADR_I(ADR_I),
        .DAT_I(DAT_I), .DAT_O(DAT_O), .LED_IN(LED_IN), .LED_OUT(LED_OUT)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct packed {
        logic [15:0] led;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state (plain integers)
    int m_en = 0, m_ben = 0, m_duty = 255, m_half = 0;
    int m_pwm = 0, m_bcnt = 0, m_phase = 1;
    int m_led = 'hFFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int adr);
        case (adr)
            0: return 32'(m_en + 2 * m_ben);
            1: return 32'(m_duty);
            2: return 32'(m_half);
            default: return 32'((m_pwm << 8) | m_phase);
        endcase
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input bit rst, input bit we, input int adr,
                              input int dat, input int led_in);
        int halfeff;
        bit lit_allowed;
        if (rst) begin
            m_en = 0; m_ben = 0; m_duty = 255; m_half = 0;
            m_pwm = 0; m_bcnt = 0; m_phase = 1; m_led = 'hFFFF;
            return;
        end
        lit_allowed = (m_en == 0) ||
                      ((m_duty == 255 || m_pwm < m_duty) && m_phase == 1);
        m_led = lit_allowed ? led_in : 'hFFFF;
        m_pwm = (m_pwm + 1) % 256;
        halfeff = (m_half == 0) ? 1 : m_half;
        if (m_ben == 0) begin
            m_bcnt = 0; m_phase = 1;
        end else if (we && adr == 2) begin
            m_bcnt = 0;
        end else if (m_bcnt + 1 >= halfeff) begin
            m_bcnt = 0; m_phase = 1 - m_phase;
        end else begin
            m_bcnt++;
        end
        if (we) begin
            case (adr)
                0: begin
                    m_en = dat & 1; m_ben = (dat >> 1) & 1;
                    if (m_ben == 0) begin m_phase = 1; m_bcnt = 0; end
                end
                1: m_duty = dat & 'hFF;
                2: m_half = dat & 'hFFFFFF;
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit we, input int adr,
                        input int dat, input int led_in);
        exp_t e;
        @(negedge CLK_I);
        RST_I = rst; WE_I = we; ADR_I = 2'(adr); DAT_I = 32'(dat); LED_IN = 16'(led_in);
        model_step(rst, we, adr, dat, led_in);
        e.led = 16'(m_led);
        e.dat = model_read(adr);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input int adr, input int led_in);
        for (int i = 0; i < n; i++) step(0, 0, adr, 0, led_in);
    endtask

    // Monitor: LED_OUT and DAT_O are presented every cycle, compared #1 after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK_I);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("led_out", {16'd0, LED_OUT}, {16'd0, e.led});
                chk("dat_o", DAT_O, e.dat);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset with LED_IN=0, EN=0: dark during reset, lit once released
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 'h0000);
        idle(4, 1, 'h0000);

        // 25% duty on bit 0
        step(0, 1, 1, 64, 'hFFFE);
        step(0, 1, 0, 1, 'hFFFE);
        idle(520, 3, 'hFFFE);

        // DUTY=0 then full on
        step(0, 1, 1, 0, 'h0000);
        idle(300, 3, 'h0000);
        step(0, 1, 1, 255, 'h0000);
        idle(300, 3, 'h0000);

        // Blink with half-period 5
        step(0, 1, 2, 5, 'h0000);
        step(0, 1, 0, 3, 'h0000);
        idle(40, 3, 'h0000);

        // BLINK_HALF write landing on the terminal-count cycle
        k = 0;
        while (m_bcnt != 4 && k < 10) begin step(0, 0, 3, 0, 'h0000); k++; end
        chk("reach_terminal", 32'(m_bcnt), 32'd4);
        step(0, 1, 2, 5, 'h0000);
        idle(20, 3, 'h0000);

        // Half-period 0: toggles every cycle
        step(0, 1, 2, 0, 'h0000);
        idle(20, 3, 'h0000);

        // Reset pulse overriding a CTRL write
        step(1, 1, 0, 3, 'h0000);
        idle(3, 0, 'h0000);
        idle(3, 3, 'h0000);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit rst, we;
            int adr, dat;
            rst = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 3) == 0);
            adr = $urandom_range(0, 3);
            case (adr)
                0: dat = $urandom_range(0, 3) | ($urandom & 32'hFFFF_FFFC);
                1: dat = ($urandom_range(0, 3) == 0) ? 255 : ($urandom & 32'hFFFF_FFFF);
                2: dat = $urandom_range(0, 7) | (($urandom & 1) << 28);
                default: dat = $urandom;
            endcase
            step(rst, we, adr, dat, $urandom & 'hFFFF);
        end

        @(posedge CLK_I);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
